// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller and its byte FIFO.
package uart_pkg;

    // Receive-controller FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WAIT  = 2'd2
    } rx_state_t;

    // Bit positions inside the CPU status/data word
    localparam int EMPTY_BIT = 15;
    localparam int OVF_BIT   = 14;

    // Default receive FIFO depth in bytes (power of two, 2..8)
    localparam int DEFAULT_DEPTH = 8;

    // Baud divider used by the UartRX block that feeds this controller
    localparam int BAUD_DIV = 217;

endpackage

// File: rtl/uart_fifo.sv
// Circular byte FIFO holding received UART bytes until the CPU pops them.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic [3:0] o_count,
    output logic       o_empty,
    output logic       o_full
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [3:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when a real pop frees the slot on the same edge.
    assign w_empty   = (r_count == 4'd0);
    assign w_full    = (r_count == FULL_COUNT);
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // Byte storage: written at the tail; contents need no reset because an empty FIFO masks the head
    always_ff @(posedge clk) begin
        if (reset_n && w_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap silently at DEPTH
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 4'd0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: captures bytes from UartRX, acknowledges them with a
// one-cycle clear strobe, buffers them in a FIFO and presents a status/data
// word to the CPU.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] rx_word,
    output logic        rx_clear,
    input  logic        rd,
    input  logic        ovf_clr,
    output logic [15:0] out
);

    rx_state_t  r_state;
    rx_state_t  w_next_state;
    logic       r_rx_clear;
    logic       w_next_rx_clear;
    logic       r_ovf;

    logic       w_byte_held;
    logic       w_push;
    logic       w_set_ovf;
    logic [7:0] w_head;
    logic [3:0] w_count;
    logic       w_empty;
    logic       w_full;
    logic       w_unused_bits;

    // UartRX flags "no byte held" in its top bit; the middle bits carry nothing for us
    assign w_byte_held   = ~rx_word[EMPTY_BIT];
    assign w_unused_bits = ^rx_word[14:8];

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (rx_word[7:0]),
        .i_pop   (rd),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // FSM state and the registered clear strobe back to UartRX
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_rx_clear <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rx_clear <= w_next_rx_clear;
        end
    end

    // Capture only from IDLE, pulse clear once, then wait for UartRX to drop the byte
    always_comb begin
        w_next_state    = r_state;
        w_next_rx_clear = 1'b0;
        w_push          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_held) begin
                    w_push          = 1'b1;
                    w_next_rx_clear = 1'b1;
                    w_next_state    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (!w_byte_held) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // A byte is lost only when the FIFO is full and the CPU is not popping
    assign w_set_ovf = w_push && w_full && !rd;

    // Sticky overflow flag; a new overflow beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_set_ovf) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // CPU word built purely from registered state; the head byte reads zero when empty
    always_comb begin
        out            = 16'h0000;
        out[EMPTY_BIT] = w_empty;
        out[OVF_BIT]   = r_ovf;
        out[11:8]      = w_count;
        out[7:0]       = w_empty ? 8'h00 : w_head;
    end

    assign rx_clear = r_rx_clear;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a UartRX environment model feeds
// bytes, a queue-based reference FIFO predicts every cycle's output, and a
// monitor compares the DUT against those predictions.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] rx_word;
    logic        rx_clear;
    logic        rd;
    logic        ovf_clr;
    logic [15:0] out;

    typedef struct packed {
        logic [15:0] outWord;
        logic        clr;
    } exp_t;

    exp_t       expQ[$];
    int         nChecks = 0;
    int         nFails  = 0;
    string      phase   = "init";

    // Reference model state: plain byte queue plus sticky flag
    logic [7:0] modelFifo[$];
    bit         modelOvf      = 1'b0;
    bit         modelCaptured = 1'b0;

    // UartRX environment state
    logic [7:0] uartQ[$];
    bit         uHeld     = 1'b0;
    logic [7:0] uByte     = 8'h00;
    bit         uPending  = 1'b0;
    int         uHoldCnt  = 0;
    int         uHoldMax  = 0;
    int         uLoadPct  = 100;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_word  (rx_word),
        .rx_clear (rx_clear),
        .rd       (rd),
        .ovf_clr  (ovf_clr),
        .out      (out)
    );

    // Compare one observed value with its prediction
    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s (%s) at %0t: got %04h, expected %04h", name, phase, $time, actual, expected);
        end
    endtask

    // CPU word the reference model says should be visible
    function automatic logic [15:0] expectedWord();
        logic [15:0] w;
        int          n;
        n = modelFifo.size();
        w = 16'h0000;
        if (n == 0) begin
            w[15] = 1'b1;
        end else begin
            w[7:0] = modelFifo[0];
        end
        w[14]    = modelOvf;
        w[11:8]  = 4'(n);
        return w;
    endfunction

    // Drive one cycle of inputs, advance the reference model and queue the prediction
    task automatic applyStimulus(input bit rstN, input int rdPct, input bit rdOnCap,
                                 input int clrPct, input bit clrOnCap);
        bit   loaded;
        bit   rdV;
        bit   clrV;
        bit   doPush;
        bit   doPop;
        bit   setOvf;
        exp_t e;
        @(negedge clk);
        loaded = 1'b0;
        if (uHeld && rx_clear === 1'b1) begin
            uPending = 1'b1;
            uHoldCnt = (uHoldMax > 0) ? int'($urandom_range(0, uHoldMax)) : 0;
        end else if (uPending) begin
            if (uHoldCnt == 0) begin
                uHeld    = 1'b0;
                uPending = 1'b0;
            end else begin
                uHoldCnt--;
            end
        end else if (!uHeld && uartQ.size() > 0 && int'($urandom_range(0, 99)) < uLoadPct) begin
            uByte         = uartQ.pop_front();
            uHeld         = 1'b1;
            loaded        = 1'b1;
            modelCaptured = 1'b0;
        end
        rdV     = (int'($urandom_range(0, 99)) < rdPct) || (rdOnCap && loaded);
        clrV    = (int'($urandom_range(0, 99)) < clrPct) || (clrOnCap && loaded);
        reset_n = rstN;
        rd      = rdV;
        ovf_clr = clrV;
        rx_word = uHeld ? {8'h00, uByte} : 16'h8000;

        doPush = 1'b0;
        if (!rstN) begin
            modelFifo.delete();
            modelOvf      = 1'b0;
            modelCaptured = 1'b0;
        end else begin
            doPush = uHeld && !modelCaptured;
            doPop  = rdV && modelFifo.size() > 0;
            setOvf = doPush && modelFifo.size() == DEPTH && !rdV;
            if (doPop) begin
                void'(modelFifo.pop_front());
            end
            if (doPush) begin
                modelCaptured = 1'b1;
                if (!setOvf) begin
                    modelFifo.push_back(uByte);
                end
            end
            if (setOvf) begin
                modelOvf = 1'b1;
            end else if (clrV) begin
                modelOvf = 1'b0;
            end
        end
        e.outWord = expectedWord();
        e.clr     = doPush;
        expQ.push_back(e);
    endtask

    // Run cycles until every queued byte has been delivered and released
    task automatic drainUart(input int rdPct, input bit rdOnCap, input int clrPct, input bit clrOnCap);
        int guard;
        guard = 0;
        while ((uartQ.size() > 0 || uHeld) && guard < 300) begin
            applyStimulus(1'b1, rdPct, rdOnCap, clrPct, clrOnCap);
            guard++;
        end
        if (guard >= 300) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain (%s): timeout with %0d bytes pending, required 0", phase, uartQ.size());
        end
    endtask

    // Spot-check a literal value just after the edge driven by the last stimulus
    task automatic expectNow(input string name, input logic [15:0] value);
        @(posedge clk);
        #2;
        checkOutput(name, out, value);
    endtask

    // Monitor: after every edge compare the DUT with the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("out", out, e.outWord);
                checkOutput("rx_clear", {15'd0, rx_clear}, {15'd0, e.clr});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        rx_word = 16'h8000;
        rd      = 1'b0;
        ovf_clr = 1'b0;

        // Byte held across reset is ignored, then captured after release
        phase = "reset hold";
        uartQ.push_back(8'h41);
        repeat (2) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
        expectNow("capture after reset", 16'h0141);
        repeat (3) applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 100, 1'b0, 0, 1'b0);
        expectNow("single pop", 16'h8000);

        // Fill to depth, then overflow
        phase = "fill";
        for (int b = 8'h11; b <= 8'h18; b++) uartQ.push_back(8'(b));
        drainUart(0, 1'b0, 0, 1'b0);
        expectNow("full", 16'h0811);
        phase = "overflow";
        uartQ.push_back(8'h19);
        drainUart(0, 1'b0, 0, 1'b0);
        expectNow("overflow", 16'h4811);

        // Clear the flag, then capture while full with a coincident pop
        phase = "full with rd";
        applyStimulus(1'b1, 0, 1'b0, 100, 1'b0);
        uartQ.push_back(8'h1A);
        drainUart(0, 1'b1, 0, 1'b0);
        expectNow("full with rd", 16'h0812);
        repeat (7) applyStimulus(1'b1, 100, 1'b0, 0, 1'b0);
        expectNow("head before last pop", 16'h011A);
        applyStimulus(1'b1, 100, 1'b0, 0, 1'b0);
        expectNow("drained", 16'h8000);

        // Pops while empty, ovf clear, and clear racing a new overflow
        phase = "empty rd";
        repeat (3) applyStimulus(1'b1, 100, 1'b0, 0, 1'b0);
        expectNow("rd while empty", 16'h8000);
        phase = "ovf clear";
        repeat (9) uartQ.push_back(8'($urandom_range(0, 255)));
        drainUart(0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, 100, 1'b0);
        expectNow("ovf cleared", {1'b0, 15'h0000} | (out & 16'hBFFF));
        checkOutput("ovf bit after clear", {15'd0, out[14]}, 16'h0000);
        uartQ.push_back(8'h77);
        drainUart(0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("ovf set beats clear", {15'd0, out[14]}, 16'h0001);

        // Reset while the controller is strobing clear
        phase = "reset in CLEAR";
        repeat (2) applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
        uartQ.push_back(8'h55);
        applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        expectNow("reset in CLEAR", 16'h8000);
        checkOutput("rx_clear in reset", {15'd0, rx_clear}, 16'h0000);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        repeat (4) applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);

        // Randomised traffic with slow UartRX release and random pops/clears
        phase = "random busy";
        uHoldMax = 2;
        uLoadPct = 50;
        for (int c = 0; c < 500; c++) begin
            if (uartQ.size() < 2) uartQ.push_back(8'($urandom_range(0, 255)));
            applyStimulus(1'b1, 25, 1'b0, 5, 1'b0);
        end
        phase = "random heavy";
        uLoadPct = 80;
        for (int c = 0; c < 300; c++) begin
            if (uartQ.size() < 2) uartQ.push_back(8'($urandom_range(0, 255)));
            applyStimulus(1'b1, 8, ($urandom_range(0, 3) == 0), 4, 1'b0);
        end

        repeat (2) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, receive FIFO depth in bytes; SHALL be a power of two, 2..8.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 rx_word  input  16  UartRX output word; bit15=1 means no byte held, bits7:0 hold the received byte when bit15=0.
REQ-005 rx_clear  output  1  registered clear strobe to UartRX.clear.
REQ-006 rd  input  1  CPU pop strobe, one byte per asserted cycle.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 out  output  16  CPU status/data word: {empty, ovf, 2'b00, count[3:0], head[7:0]}.

Function
REQ-009 The FSM SHALL have states IDLE, CLEAR and WAIT.
REQ-010 IDLE with rx_word[15]=0 at an edge: push rx_word[7:0], or set ovf if full and rd=0; set rx_clear<=1; go to CLEAR.
REQ-011 CLEAR: rx_clear<=0 and go to WAIT; rx_clear SHALL be high exactly one cycle per captured byte.
REQ-012 WAIT: stay until rx_word[15]=1, then go to IDLE; no byte SHALL be captured in CLEAR or WAIT.
REQ-013 FIFO push/pop SHALL be circular; pointers are log2(DEPTH) bits and wrap silently; count ranges 0..DEPTH.
REQ-014 rd with count=0 SHALL be ignored: no pointer or count change.
REQ-015 Simultaneous push and rd with count>0 SHALL keep count unchanged and advance both pointers.
REQ-016 Push when full with rd=0 SHALL drop the byte and set ovf; push when full with rd=1 SHALL store it and leave ovf unchanged.
REQ-017 ovf SHALL be sticky until ovf_clr; if set and clear occur on the same edge, set wins.
REQ-018 out SHALL be decoded combinationally from registers only, with no input-to-output path.
REQ-019 out[15] SHALL be 1 iff count=0; when empty, head[7:0] SHALL read 8'h00.
REQ-020 A byte pushed into an empty FIFO SHALL appear on out on the cycle after the capture edge.
REQ-021 After a pop, out SHALL show the next head on the following cycle.

Reset
REQ-022 With reset_n=0 at an edge: state=IDLE, rx_clear=0, pointers=0, count=0, ovf=0; out SHALL read 16'h8000.
REQ-023 Reset SHALL override all other inputs, including during CLEAR or WAIT.
REQ-024 A byte still held by UartRX after reset release SHALL be captured normally from IDLE.

Structure
REQ-025 The shared package uart_pkg SHALL hold the FSM state encoding, EMPTY_BIT=15, OVF_BIT=14, the default DEPTH and BAUD_DIV=217.
REQ-026 FIFO storage and pointers SHALL live in one sub-module, uart_fifo; the FSM and out decode SHALL stay in uart_rx_ctrl.

Verification
REQ-027 Reset: reset_n=0 for 2 cycles with rx_word=16'h0041 -> out=16'h8000 and rx_clear=0 throughout; after release, one rx_clear pulse and out=16'h0141.
REQ-028 Single byte: UartRX model delivers 0x41 -> exactly one rx_clear pulse; out=16'h0141 one cycle after capture; one rd -> out=16'h8000.
REQ-029 Fill/overflow: bytes 0x11..0x18 with no rd -> out=16'h0811; 9th byte 0x19 -> one rx_clear pulse, out=16'h4811.
REQ-030 Full with rd coincident with capture of 0x1A -> count stays 8, ovf unchanged, out=16'h0812 next cycle; the 8th pop returns 0x1A.
REQ-031 rd while empty -> out stays 16'h8000; ovf set plus ovf_clr -> bit14=0; ovf_clr on the same edge as an overflow -> bit14=1.
REQ-032 Reset asserted during CLEAR -> rx_clear=0 and state IDLE next cycle, FIFO empty, no extra pulse while reset_n=0.
